// File: rtl/game_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// game_input_conditioner_if
//   Bundles the per-bit game-controller signals that pass between the board
//   input side and the input conditioner.
//
//   raw_in        : asynchronous raw button/switch levels
//   clear_pressed : per-bit synchronous clear strobe for pressed_latch
//   stable_out    : debounced active-high levels (feeds the PIO in_port)
//   press_pulse   : one-cycle pulse on each debounced 0->1 transition
//   pressed_latch : sticky record of presses since the last clear
//
//   master : drives raw_in / clear_pressed, observes the conditioned outputs
//   slave  : the conditioner itself
// -----------------------------------------------------------------------------
interface game_input_conditioner_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] clear_pressed;
    logic [WIDTH-1:0] stable_out;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] pressed_latch;

    modport master (
        output raw_in,
        output clear_pressed,
        input  stable_out,
        input  press_pulse,
        input  pressed_latch
    );

    modport slave (
        input  raw_in,
        input  clear_pressed,
        output stable_out,
        output press_pulse,
        output pressed_latch
    );
endinterface

// File: rtl/game_input_conditioner.sv
// -----------------------------------------------------------------------------
// game_input_conditioner
//   Conditions raw board buttons/switches for an 8-bit bus-input PIO:
//   two-flop synchronisation into clk, optional inversion of active-low
//   inputs, independent per-bit debouncing, a registered one-cycle press
//   pulse and a sticky per-bit pressed latch with a synchronous clear.
//
//   Ports:
//     clk   : system clock (same clock as the bus-input PIO)
//     reset : asynchronous, active-high reset
//     bus   : game_input_conditioner_if.slave
//               raw_in, clear_pressed (in)
//               stable_out, press_pulse, pressed_latch (out)
//
//   Parameters:
//     WIDTH           : number of input bits
//     DEBOUNCE_CYCLES : consecutive cycles a new level must hold (1..2^CNT_W-1)
//     CNT_W           : width of each per-bit debounce counter
//     ACTIVE_LOW      : 1 = raw inputs are active-low and get inverted
// -----------------------------------------------------------------------------
module game_input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    game_input_conditioner_if.slave  bus
);

    // Level the synchroniser holds in reset, so that reset release never
    // looks like a press.
    localparam logic [WIDTH-1:0] INACTIVE = {WIDTH{ACTIVE_LOW}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if ((DEBOUNCE_CYCLES < 1) ||
        (longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_debounce
        $error("game_input_conditioner: DEBOUNCE_CYCLES must be in 1..2^CNT_W-1");
    end

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] sync_q;
    logic [CNT_W-1:0] cnt_p2 [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] stable_p2;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] press_pulse_p2;
    logic [WIDTH-1:0] latch_p3;

    // ---- stage p0/p1: two-flop synchroniser --------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= INACTIVE;
            sync_p1 <= INACTIVE;
        end else begin
            sync_p0 <= bus.raw_in;
            sync_p1 <= sync_p0;
        end
    end

    assign sync_q = ACTIVE_LOW ? ~sync_p1 : sync_p1;

    // ---- stage p2: per-bit debounce ----------------------------------------
    // The counter only runs while the synchronised level disagrees with the
    // accepted level; any agreement restarts it, so short glitches are lost.
    // It stops at CNT_LAST (the accept point), so it can never wrap.
    always_comb begin
        stable_nxt = stable_p2;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync_q[i] != stable_p2[i]) begin
                if (cnt_p2[i] == CNT_LAST) begin
                    stable_nxt[i] = sync_q[i];
                end else begin
                    cnt_nxt[i] = cnt_p2[i] + 1'b1;
                end
            end
        end
    end

    // The press pulse is registered on the same edge as the accepted level,
    // so it is high exactly in the first cycle stable_out shows the 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_p2[i] <= '0;
            end
            stable_p2      <= '0;
            press_pulse_p2 <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_p2[i] <= cnt_nxt[i];
            end
            stable_p2      <= stable_nxt;
            press_pulse_p2 <= stable_nxt & ~stable_p2;
        end
    end

    // ---- stage p3: sticky pressed latch ------------------------------------
    // Set takes priority over clear, so a clear issued in the same cycle as a
    // press pulse cannot swallow that press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_p3 <= '0;
        end else begin
            latch_p3 <= press_pulse_p2 | (latch_p3 & ~bus.clear_pressed);
        end
    end

    assign bus.stable_out    = stable_p2;
    assign bus.press_pulse   = press_pulse_p2;
    assign bus.pressed_latch = latch_p3;

endmodule

// File: tb/tb_game_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_game_input_conditioner
//   Directed scenarios followed by randomized button activity, with every
//   cycle compared against a time-stamp based behavioural model.
// -----------------------------------------------------------------------------
module tb_game_input_conditioner;

    localparam int WIDTH = 8;
    localparam int DEB   = 4;

    logic clk;
    logic reset;

    game_input_conditioner_if #(.WIDTH(WIDTH)) bus ();

    game_input_conditioner #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (20),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // raw_hist[k] is the raw level present at the (k+1)-th most recent edge.
    // A bit is accepted once it has disagreed with the accepted level at DEB
    // consecutive edges, measured from the edge where the disagreement began.
    logic [WIDTH-1:0] m_stable = '0;
    logic [WIDTH-1:0] m_pulse  = '0;
    logic [WIDTH-1:0] m_latch  = '0;
    logic [WIDTH-1:0] raw_hist [$] = '{8'hFF, 8'hFF};
    int               diff_start [WIDTH];
    int               edge_n = 0;

    initial begin
        for (int i = 0; i < WIDTH; i++) diff_start[i] = -1;
    end

    always @(posedge clk) begin
        logic [WIDTH-1:0] sync_v;
        logic [WIDTH-1:0] nstable;
        edge_n++;
        if (reset) begin
            m_stable = '0;
            m_pulse  = '0;
            m_latch  = '0;
            raw_hist = '{8'hFF, 8'hFF};
            for (int i = 0; i < WIDTH; i++) diff_start[i] = -1;
        end else begin
            sync_v  = ~raw_hist[1];
            nstable = m_stable;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_v[i] != m_stable[i]) begin
                    if (diff_start[i] < 0) diff_start[i] = edge_n;
                    if (edge_n - diff_start[i] + 1 >= DEB) begin
                        nstable[i]    = sync_v[i];
                        diff_start[i] = -1;
                    end
                end else begin
                    diff_start[i] = -1;
                end
            end
            m_latch  = m_pulse | (m_latch & ~bus.clear_pressed);
            m_pulse  = nstable & ~m_stable;
            m_stable = nstable;
            raw_hist.push_front(bus.raw_in);
            void'(raw_hist.pop_back());
        end
    end

    // One clock: edge, then compare everything on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_eq("model_stable", bus.stable_out, m_stable);
        check_eq("model_pulse", bus.press_pulse, m_pulse);
        check_eq("model_latch", bus.pressed_latch, m_latch);
    endtask

    // Reset for exactly one edge; outputs must clear before any edge.
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check_eq("async_rst_stable", bus.stable_out, 0);
        check_eq("async_rst_pulse", bus.press_pulse, 0);
        check_eq("async_rst_latch", bus.pressed_latch, 0);
        tick();
        reset = 1'b0;
    endtask

    int hold_left [WIDTH];

    initial begin
        reset             = 1'b1;
        bus.raw_in        = 8'hFF;
        bus.clear_pressed = '0;

        // 1: reset with everything released, then 20 quiet cycles
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check_eq("idle_stable", bus.stable_out, 0);
            check_eq("idle_pulse", bus.press_pulse, 0);
            check_eq("idle_latch", bus.pressed_latch, 0);
        end

        // 2: press bit 0 and hold; accepted on the 6th edge
        bus.raw_in[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq("press0_stable", bus.stable_out[0], (k >= 6));
            check_eq("press0_pulse", bus.press_pulse[0], (k == 6));
            check_eq("press0_latch", bus.pressed_latch[0], (k >= 7));
        end

        // 3: five 3-cycle glitches on bit 1 never get through
        for (int g = 0; g < 5; g++) begin
            bus.raw_in[1] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                check_eq("glitch1_bits", {bus.stable_out[1], bus.press_pulse[1], bus.pressed_latch[1]}, 0);
            end
            bus.raw_in[1] = 1'b1;
            for (int k = 0; k < 2; k++) begin
                tick();
                check_eq("glitch1_bits", {bus.stable_out[1], bus.press_pulse[1], bus.pressed_latch[1]}, 0);
            end
        end

        // 4: clear coinciding with a new press keeps the latch set
        bus.raw_in[0] = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check_eq("rel0_stable", bus.stable_out[0], 0);
        bus.raw_in[0] = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check_eq("repress0_pulse", bus.press_pulse[0], 1);
        check_eq("repress0_latch", bus.pressed_latch[0], 1);
        bus.clear_pressed[0] = 1'b1;
        tick();
        bus.clear_pressed[0] = 1'b0;
        check_eq("set_wins_latch", bus.pressed_latch[0], 1);
        for (int k = 0; k < 3; k++) tick();
        bus.clear_pressed[0] = 1'b1;
        tick();
        bus.clear_pressed[0] = 1'b0;
        check_eq("clear0_latch", bus.pressed_latch[0], 0);

        // 5: bits 2 and 7 together, bit 2 released after 10 cycles
        bus.raw_in[2] = 1'b0;
        bus.raw_in[7] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_eq("pair_stable", {bus.stable_out[7], bus.stable_out[2]}, (k >= 6) ? 2'b11 : 2'b00);
            check_eq("pair_pulse", {bus.press_pulse[7], bus.press_pulse[2]}, (k == 6) ? 2'b11 : 2'b00);
        end
        bus.raw_in[2] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check_eq("rel2_stable", bus.stable_out[2], (k < 6));
            check_eq("rel2_pulse", bus.press_pulse[2], 0);
            check_eq("hold7_stable", bus.stable_out[7], 1);
        end

        // 6: reset two cycles before bit 3 would be accepted
        bus.raw_in[3] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check_eq("pre_rst3_stable", bus.stable_out[3], 0);
        pulse_reset();
        for (int k = 1; k <= 7; k++) begin
            tick();
            check_eq("rst3_stable", bus.stable_out[3], (k >= 6));
            check_eq("rst3_pulse", bus.press_pulse[3], (k == 6));
        end

        // Randomized activity: per-bit hold times of 1..9 cycles, sparse
        // clears, occasional resets.
        for (int i = 0; i < WIDTH; i++) hold_left[i] = $urandom_range(1, 9);
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (hold_left[i] == 0) begin
                    bus.raw_in[i] = ~bus.raw_in[i];
                    hold_left[i]  = $urandom_range(1, 9);
                end else begin
                    hold_left[i]--;
                end
            end
            bus.clear_pressed = WIDTH'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 149) == 0) begin
                pulse_reset();
            end else begin
                tick();
            end
        end
        bus.clear_pressed = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
